// File: rtl/da_dot_param_if.sv
// Sample/result handshake bundle for da_dot_param.
//   in_valid/in_ready/x_flat   : sample vector in, X[j] = x_flat[j*XW +: XW]
//   out_valid/out_ready/y      : signed dot product out, held until accepted
// master = producer of samples / consumer of results; slave = the engine.
interface da_dot_param_if #(
  parameter int unsigned NTAPS = 4,
  parameter int unsigned XW    = 8,
  parameter int unsigned CW    = 32
);
  localparam int unsigned OW = CW + XW + $clog2(NTAPS);

  logic                   in_valid;
  logic                   in_ready;
  logic [NTAPS*XW-1:0]    x_flat;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [OW-1:0]   y;

  modport master (
    output in_valid, x_flat, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x_flat, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/da_dot_param.sv
// Distributed-arithmetic dot product y = sum_j C[j]*X[j] (signed, exact).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   coef_load_i   : pulse in IDLE to capture coef_flat_i and rebuild the LUT
//   coef_flat_i   : C[j] = coef_flat_i[j*CW +: CW]
//   lut_valid_o   : LUT holds sums of a loaded coefficient set
//   busy_o        : engine not in IDLE
//   bus           : sample/result handshake (slave side)
// The LUT holds every partial sum of coefficients; one LUT lookup per sample bit,
// MSB first, with the sign bit weighted negatively.
module da_dot_param #(
  parameter int unsigned NTAPS = 4,
  parameter int unsigned XW    = 8,
  parameter int unsigned CW    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coef_load_i,
  input  logic [NTAPS*CW-1:0] coef_flat_i,
  output logic               lut_valid_o,
  output logic               busy_o,
  da_dot_param_if.slave      bus
);
  localparam int unsigned AW    = $clog2(NTAPS);
  localparam int unsigned LW    = CW + AW;
  localparam int unsigned OW    = CW + XW + AW;
  localparam int unsigned Depth = 2 ** NTAPS;
  localparam int unsigned BW    = $clog2(XW);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StBuild   = 2'd1;
  localparam logic [1:0] StCompute = 2'd2;
  localparam logic [1:0] StOut     = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 lut_valid_q, lut_valid_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [OW-1:0] y_q, y_d;
  logic signed [OW-1:0] acc_q, acc_d;
  logic [BW-1:0]        b_q, b_d;
  logic [NTAPS-1:0]     k_q, k_d;

  // Datapath storage, no reset needed (contents are don't-care until loaded).
  logic [CW-1:0]        coef_q [NTAPS];
  logic [LW-1:0]        lut_q  [Depth];
  logic [XW-1:0]        x_q    [NTAPS];

  logic                 in_ready;
  logic                 capture;
  logic [AW-1:0]        msb;
  logic [NTAPS-1:0]     k_clr;
  logic [LW-1:0]        entry;
  logic [NTAPS-1:0]     addr;
  logic signed [OW-1:0] lut_ext;

  assign in_ready      = (state_q == StIdle) && lut_valid_q && !coef_load_i;
  assign capture       = in_ready && bus.in_valid;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign lut_valid_o   = lut_valid_q;
  assign busy_o        = (state_q != StIdle);

  // LUT entry k = entry k-without-its-top-bit + C[top bit]; lower entries are already built.
  always_comb begin
    msb = '0;
    for (int j = 0; j < NTAPS; j++) begin
      if (k_q[j]) msb = AW'(j);
    end
    k_clr      = k_q;
    k_clr[msb] = 1'b0;
    if (k_q == '0) entry = '0;
    else           entry = lut_q[k_clr] + {{AW{coef_q[msb][CW-1]}}, coef_q[msb]};
  end

  // Current bit of every tap forms the LUT address (tap 0 = address bit 0).
  always_comb begin
    for (int j = 0; j < NTAPS; j++) addr[j] = x_q[j][XW-1];
    lut_ext = {{XW{lut_q[addr][LW-1]}}, lut_q[addr]};
  end

  always_comb begin
    state_d     = state_q;
    lut_valid_d = lut_valid_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    acc_d       = acc_q;
    b_d         = b_q;
    k_d         = k_q;
    case (state_q)
      StIdle: begin
        if (coef_load_i) begin
          lut_valid_d = 1'b0;
          k_d         = '0;
          state_d     = StBuild;
        end else if (capture) begin
          b_d     = BW'(XW - 1);
          acc_d   = '0;
          state_d = StCompute;
        end
      end
      StBuild: begin
        k_d = k_q + NTAPS'(1);
        if (k_q == NTAPS'(Depth - 1)) begin
          lut_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StCompute: begin
        // Sign bit carries negative weight in two's complement.
        if (b_q == BW'(XW - 1)) acc_d = -lut_ext;
        else                    acc_d = (acc_q <<< 1) + lut_ext;
        b_d = b_q - BW'(1);
        if (b_q == '0) begin
          y_d         = acc_d;
          out_valid_d = 1'b1;
          state_d     = StOut;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lut_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      k_q         <= '0;
    end else begin
      state_q     <= state_d;
      lut_valid_q <= lut_valid_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      k_q         <= k_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StIdle && coef_load_i) begin
      for (int j = 0; j < NTAPS; j++) coef_q[j] <= coef_flat_i[j*CW +: CW];
    end
    if (state_q == StBuild) lut_q[k_q] <= entry;
    if (capture) begin
      for (int j = 0; j < NTAPS; j++) x_q[j] <= bus.x_flat[j*XW +: XW];
    end else if (state_q == StCompute) begin
      for (int j = 0; j < NTAPS; j++) x_q[j] <= x_q[j] << 1;
    end
  end
endmodule

// File: tb/tb_da_dot_param.sv
// Self-checking bench for da_dot_param (NTAPS=4, XW=8, CW=32).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_da_dot_param;
  localparam int unsigned NTAPS = 4;
  localparam int unsigned XW    = 8;
  localparam int unsigned CW    = 32;
  localparam int unsigned OW    = CW + XW + $clog2(NTAPS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic coef_load = 1'b0;
  logic [NTAPS*CW-1:0] coef_flat = '0;
  logic lut_valid, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [CW-1:0] cm [NTAPS];
  logic signed [XW-1:0] xm [NTAPS];

  da_dot_param_if #(.NTAPS(NTAPS), .XW(XW), .CW(CW)) bus ();

  da_dot_param #(.NTAPS(NTAPS), .XW(XW), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coef_load_i (coef_load),
    .coef_flat_i (coef_flat),
    .lut_valid_o (lut_valid),
    .busy_o      (busy),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic signed [OW-1:0] model();
    longint s = 0;
    for (int j = 0; j < NTAPS; j++) s += longint'(cm[j]) * longint'(xm[j]);
    return OW'(s);
  endfunction

  task automatic load_coefs(output int cycles);
    @(negedge clk);
    for (int j = 0; j < NTAPS; j++) coef_flat[j*CW +: CW] = cm[j];
    coef_load = 1'b1;
    @(negedge clk);
    coef_load = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    n_checks++;
    if (lut_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL load_lut_valid: got %b want 1", lut_valid);
    end
  endtask

  task automatic run_vector(input logic signed [OW-1:0] exp_y, input string tag);
    int n;
    @(negedge clk);
    for (int j = 0; j < NTAPS; j++) bus.x_flat[j*XW +: XW] = xm[j];
    bus.in_valid = 1'b1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_in_ready: got %b want 1", tag, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != XW) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d edges want %0d", tag, n, XW);
    end
    n_checks++;
    if (bus.y !== exp_y) begin
      n_fail++;
      $display("FAIL %s_y: got %0d want %0d", tag, bus.y, exp_y);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.y !== exp_y) begin
      n_fail++;
      $display("FAIL %s_drain: out_valid=%b busy=%b y=%0d want 0 0 %0d",
               tag, bus.out_valid, busy, bus.y, exp_y);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || lut_valid !== 1'b0 || bus.y !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b lut_valid=%b y=%0d busy=%b want all 0",
               bus.out_valid, lut_valid, bus.y, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_lut_reject: %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_basic();
    int cyc;
    cm = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
    load_coefs(cyc);
    n_checks++;
    if (cyc != 2 ** NTAPS) begin
      n_fail++;
      $display("FAIL build_cycles: got %0d want %0d", cyc, 2 ** NTAPS);
    end
    xm = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    run_vector(OW'(10), "basic");
  endtask

  task automatic test_signs();
    int cyc;
    cm = '{32'sd1, 32'sd1, 32'sd1, 32'sd1};
    load_coefs(cyc);
    xm = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
    run_vector(-OW'(512), "neg128");
    cm = '{32'sd3, 32'sd5, 32'sd7, -32'sd2};
    load_coefs(cyc);
    xm = '{8'sd127, -8'sd1, 8'sd0, -8'sd128};
    run_vector(OW'(632), "mixed");
  endtask

  task automatic test_extreme();
    int cyc;
    logic signed [OW-1:0] want;
    want = -OW'(4 * 128 * 64'sd2147483647);
    cm = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
    load_coefs(cyc);
    xm = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
    run_vector(want, "extreme");
  endtask

  task automatic test_random();
    int cyc;
    for (int s = 0; s < 6; s++) begin
      for (int j = 0; j < NTAPS; j++) cm[j] = $urandom;
      load_coefs(cyc);
      for (int v = 0; v < 3; v++) begin
        for (int j = 0; j < NTAPS; j++) xm[j] = XW'($urandom);
        run_vector(model(), "random");
      end
    end
  endtask

  task automatic test_stall();
    int cyc, n, bad;
    logic signed [OW-1:0] want;
    cm = '{32'sd11, -32'sd7, 32'sd300, 32'sd2};
    load_coefs(cyc);
    xm = '{8'sd45, -8'sd99, 8'sd3, 8'sd127};
    want = model();
    @(negedge clk);
    for (int j = 0; j < NTAPS; j++) bus.x_flat[j*XW +: XW] = xm[j];
    bus.in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.y !== want || bus.in_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d bad cycles want 0 (y=%0d want %0d)", bad, bus.y, want);
    end
    bus.in_valid = 1'b0;
    coef_flat = '0;
    coef_load = 1'b1;
    @(negedge clk);
    coef_load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (lut_valid !== 1'b1 || busy !== 1'b1 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_load_ignored: lut_valid=%b busy=%b out_valid=%b want 1 1 1",
               lut_valid, busy, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    run_vector(want, "after_stall");
  endtask

  task automatic test_back_to_back();
    int t, t1, t2;
    logic signed [OW-1:0] want;
    xm = '{-8'sd5, 8'sd17, -8'sd64, 8'sd9};
    want = model();
    @(negedge clk);
    for (int j = 0; j < NTAPS; j++) bus.x_flat[j*XW +: XW] = xm[j];
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    t = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && t < 60) begin
      @(negedge clk);
      t++;
      if (bus.out_valid === 1'b1) begin
        if (t1 < 0) t1 = t;
        else        t2 = t;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++;
    if (t2 - t1 != XW + 2 || t1 < 0) begin
      n_fail++;
      $display("FAIL b2b_interval: got %0d want %0d", t2 - t1, XW + 2);
    end
    n_checks++;
    if (bus.y !== want) begin
      n_fail++;
      $display("FAIL b2b_y: got %0d want %0d", bus.y, want);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    xm = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    for (int j = 0; j < NTAPS; j++) bus.x_flat[j*XW +: XW] = xm[j];
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.y !== '0 || lut_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: out_valid=%b y=%0d lut_valid=%b busy=%b want all 0",
               bus.out_valid, bus.y, lut_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_flat    = '0;
    test_reset();
    test_basic();
    test_signs();
    test_extreme();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
